// File: rtl/iob_clint_rtc_tick_pkg.sv
// Shared register map, control-bit positions and tick-source encoding for the
// CLINT real-time tick generator.
package iob_clint_rtc_tick_pkg;

    localparam int unsigned CTRL_ADDR = 0;
    localparam int unsigned DIV_ADDR  = 4;
    localparam int unsigned CNT_ADDR  = 8;

    localparam int unsigned EN_BIT  = 0;
    localparam int unsigned SRC_BIT = 1;

    typedef enum logic {
        SRC_EXT = 1'b0,
        SRC_INT = 1'b1
    } src_e;

    // Merge write data into a 32-bit register under a byte-enable mask.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_clint_rtc_tick_if.sv
// IOb native register port between a bus master and the tick generator.
interface iob_clint_rtc_tick_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_clint_rtc_sync.sv
// Three-flop synchronizer for the asynchronous rtc pin with rising-edge detect
// taken between the second and third stages.
module iob_clint_rtc_sync (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], in};
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/iob_clint_rtc_tick.sv
// Generates the clk-synchronous rtc_tick enable for CLINT mtime, from either the
// synchronized rtc pin or an internal clock divider, with an IOb register port.
module iob_clint_rtc_tick
    import iob_clint_rtc_tick_pkg::*;
#(
    parameter int               ADDR_W   = 4,
    parameter int               DATA_W   = 32,
    parameter int               FREQ     = 100000000,
    parameter int               RTC_FREQ = 32768,
    parameter logic [DATA_W-1:0] DIV_RST = DATA_W'(FREQ / RTC_FREQ),
    parameter bit               SRC_RST  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rtc,
    iob_clint_rtc_tick_if.slave  bus,
    output logic                 rtc_tick
);

    logic              en_q, en_d;
    src_e              src_q, src_d;
    logic [DATA_W-1:0] div_q, div_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              tick_q, tick_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              ext_edge;
    logic              wr, rd;
    logic              sel_ctrl, sel_div, sel_cnt;
    logic              div_wr, src_chg, run, wrap;
    logic [DATA_W-1:0] divm1;
    logic [DATA_W-1:0] ctrl_rd;

    iob_clint_rtc_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .in     (rtc),
        .edge_o (ext_edge)
    );

    always_comb begin
        wr       = bus.valid && (bus.wstrb != '0);
        rd       = bus.valid && (bus.wstrb == '0);
        sel_ctrl = (bus.address == ADDR_W'(CTRL_ADDR));
        sel_div  = (bus.address == ADDR_W'(DIV_ADDR));
        sel_cnt  = (bus.address == ADDR_W'(CNT_ADDR));

        en_d  = en_q;
        src_d = src_q;
        if (wr && sel_ctrl && bus.wstrb[0]) begin
            en_d  = bus.wdata[EN_BIT];
            src_d = bus.wdata[SRC_BIT] ? SRC_INT : SRC_EXT;
        end

        div_wr = wr && sel_div;
        div_d  = div_wr ? apply_wstrb(div_q, bus.wdata, bus.wstrb) : div_q;

        // Switching source clears the divider and masks the tick registered on
        // the same edge, so the old source cannot leak a glitch tick through.
        src_chg = wr && sel_ctrl && (src_d != src_q);

        // DIV=0 behaves as DIV=1: terminal count is 0, tick every cycle.
        divm1 = (div_q == '0) ? '0 : div_q - DATA_W'(1);
        run   = en_q && (src_q == SRC_INT);
        wrap  = run && (c_q == divm1);

        if (!run || wrap) c_d = '0;
        else              c_d = c_q + DATA_W'(1);
        if (div_wr || src_chg) c_d = '0;

        tick_d = 1'b0;
        if (en_q && !src_chg) tick_d = (src_q == SRC_EXT) ? ext_edge : wrap;

        cnt_d = cnt_q + DATA_W'(tick_d);
        if (wr && sel_cnt) cnt_d = '0;

        ctrl_rd          = '0;
        ctrl_rd[EN_BIT]  = en_q;
        ctrl_rd[SRC_BIT] = (src_q == SRC_INT);

        ready_d = bus.valid;
        rdata_d = '0;
        if (rd) begin
            if (sel_ctrl)     rdata_d = ctrl_rd;
            else if (sel_div) rdata_d = div_q;
            else if (sel_cnt) rdata_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b1;
            src_q   <= SRC_RST ? SRC_INT : SRC_EXT;
            div_q   <= DIV_RST;
            cnt_q   <= '0;
            c_q     <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            src_q   <= src_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign rtc_tick  = tick_q;

endmodule

// File: tb/tb_iob_clint_rtc_tick.sv
// Self-checking bench for iob_clint_rtc_tick: register table, external and
// internal tick sources, enable, CNT clear/wrap and mid-operation reset.
module tb_iob_clint_rtc_tick;
    import iob_clint_rtc_tick_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam logic [3:0] A_CTRL = 4'h0;
    localparam logic [3:0] A_DIV  = 4'h4;
    localparam logic [3:0] A_CNT  = 4'h8;
    localparam logic [3:0] A_NONE = 4'hC;

    logic clk = 1'b0;
    logic rst;
    logic rtc;
    logic rtc_tick;

    iob_clint_rtc_tick_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_clint_rtc_tick #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FREQ     (100000000),
        .RTC_FREQ (32768),
        .SRC_RST  (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rtc      (rtc),
        .bus      (bus),
        .rtc_tick (rtc_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[18];
    logic [31:0] sb_q[$];
    int          tick_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] sb_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int ticks_between(input int lo, input int hi);
        int n = 0;
        foreach (tick_log[i]) if (tick_log[i] > lo && tick_log[i] < hi) n++;
        return n;
    endfunction

    function automatic int has_tick(input int c);
        return (ticks_between(c - 1, c + 1) > 0) ? 1 : 0;
    endfunction

    // Called at a negedge; the request is sampled by the next posedge.
    task automatic req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp);
        bus.valid   = 1'b1;
        bus.address = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        req(a, d, 4'hF, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        req(a, 32'h0, 4'h0, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Response monitor: ready one cycle after each accepted valid, rdata popped
    // from the scoreboard, and every tick logged with its cycle number.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rtc_tick === 1'b1) tick_log.push_back(cyc);
        if (mon_en) begin
            check("ready", 32'(bus.ready), 32'(bus.valid & ~rst));
            if (bus.ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: ready=1 with no request pending (cycle %0d)", cyc);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("rdata", bus.rdata, sb_e);
                end
            end else begin
                check("rdata_idle", bus.rdata, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        int rise[5];
        int w0, wc, wd, wx, we, r, n;

        rst = 1'b1; rtc = 1'b0;
        bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;

        vecs[0]  = '{A_CTRL, 32'h0,          4'h0, 32'h1};
        vecs[1]  = '{A_DIV,  32'h0,          4'h0, 32'd3051};
        vecs[2]  = '{A_CNT,  32'h0,          4'h0, 32'h0};
        vecs[3]  = '{A_NONE, 32'h0,          4'h0, 32'h0};
        vecs[4]  = '{A_DIV,  32'h1234_5678,  4'hF, 32'h0};
        vecs[5]  = '{A_DIV,  32'h0,          4'h0, 32'h1234_5678};
        vecs[6]  = '{A_DIV,  32'hAABB_CCDD,  4'h5, 32'h0};
        vecs[7]  = '{A_DIV,  32'h0,          4'h0, 32'h12BB_56DD};
        vecs[8]  = '{A_NONE, 32'hFFFF_FFFF,  4'hF, 32'h0};
        vecs[9]  = '{A_NONE, 32'h0,          4'h0, 32'h0};
        vecs[10] = '{A_CTRL, 32'hFFFF_FFFC,  4'h1, 32'h0};
        vecs[11] = '{A_CTRL, 32'h0,          4'h0, 32'h0};
        vecs[12] = '{A_CTRL, 32'h0000_0003,  4'h2, 32'h0};
        vecs[13] = '{A_CTRL, 32'h0,          4'h0, 32'h0};
        vecs[14] = '{A_CTRL, 32'h0000_0001,  4'h1, 32'h0};
        vecs[15] = '{A_CTRL, 32'h0,          4'h0, 32'h1};
        vecs[16] = '{A_DIV,  32'd3051,       4'hF, 32'h0};
        vecs[17] = '{A_DIV,  32'h0,          4'h0, 32'd3051};

        // Reset state
        idle(3);
        check("rst_tick",  32'(rtc_tick), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("tick_after_rst", 32'(rtc_tick), 32'h0);

        // Register table, issued back-to-back
        for (int i = 0; i < 18; i++) req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp);
        idle(2);

        // External source: 5 periods of 40 cycles
        tick_log.delete();
        for (int k = 0; k < 5; k++) begin
            rise[k] = cyc + 3;
            rtc = 1'b1; idle(20);
            rtc = 1'b0; idle(20);
        end
        check("ext_tick_count", 32'(tick_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < tick_log.size(); i++)
            check("ext_tick_cycle", 32'(tick_log[i]), 32'(rise[i]));
        rd(A_CNT, 32'd5);

        // Internal divider, DIV=10
        tick_log.delete();
        w0 = cyc + 1; wr(A_CTRL, 32'h3);
        wc = cyc + 1; wr(A_CNT, 32'h0);
        wd = cyc + 1; wr(A_DIV, 32'd10);
        while (cyc < wd + 101) @(negedge clk);
        rd(A_CNT, 32'd10);
        check("no_tick_after_switch", 32'(has_tick(w0)), 32'h0);
        check("int_tick_count", 32'(tick_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < tick_log.size(); i++)
            check("int_tick_cycle", 32'(tick_log[i]), 32'(wd + 10 * (i + 1)));

        // DIV=0 and DIV=1 tick every cycle
        wd = cyc + 1; wr(A_DIV, 32'd0); idle(6);
        check("div0_every_cycle", 32'(ticks_between(wd, wd + 6)), 32'd5);
        wd = cyc + 1; wr(A_DIV, 32'd1); idle(6);
        check("div1_every_cycle", 32'(ticks_between(wd, wd + 6)), 32'd5);

        // Disable: no ticks, CNT frozen
        wx = cyc + 1; wr(A_CTRL, 32'h2);
        idle(3);
        n = ticks_between(wc, wx + 1);
        rd(A_CNT, 32'(n));
        idle(10);
        rd(A_CNT, 32'(n));
        check("no_tick_disabled", 32'(ticks_between(wx, cyc + 1)), 32'h0);

        // Re-enable on external source with rtc already high
        rtc = 1'b1; idle(5);
        we = cyc + 1; wr(A_CTRL, 32'h1);
        idle(10);
        check("no_spurious_reenable", 32'(ticks_between(wx, cyc + 1)), 32'h0);
        rtc = 1'b0; idle(5);
        r = cyc + 3; rtc = 1'b1; idle(6);
        check("tick_next_rise", 32'(has_tick(r)), 32'h1);
        check("single_tick_after_reenable", 32'(ticks_between(we, cyc + 1)), 32'h1);
        rtc = 1'b0; idle(5);

        // CNT write in the same cycle as a tick: clear wins
        r = cyc + 3; rtc = 1'b1; idle(2);
        wr(A_CNT, 32'h0);
        rd(A_CNT, 32'h0);
        check("collision_tick_fired", 32'(has_tick(r)), 32'h1);
        rtc = 1'b0; idle(5);

        // CNT wrap from a preloaded value, DIV=1 on internal source
        wr(A_DIV, 32'd1);
        wr(A_CTRL, 32'h3);
        idle(3);
        n = cyc;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        idle(5);
        wx = cyc + 1; wr(A_CTRL, 32'h2);
        idle(2);
        check("wrap_tick_count", 32'(ticks_between(n, wx + 1)), 32'd6);
        rd(A_CNT, 32'hFFFF_FFFE + 32'(ticks_between(n, wx + 1)));

        // Reset asserted mid-divide (c=5 with DIV=10)
        wr(A_CTRL, 32'h3);
        wd = cyc + 1; wr(A_DIV, 32'd10);
        while (cyc < wd + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); check("tick_during_rst0", 32'(rtc_tick), 32'h0);
        @(negedge clk); check("tick_during_rst1", 32'(rtc_tick), 32'h0);
        rst = 1'b0;
        @(negedge clk); check("tick_after_midrst", 32'(rtc_tick), 32'h0);
        idle(6);
        check("no_tick_after_midrst", 32'(ticks_between(wd, cyc + 1)), 32'h0);
        rd(A_CTRL, 32'h1);
        rd(A_DIV,  32'd3051);
        rd(A_CNT,  32'h0);
        rd(A_NONE, 32'h0);
        idle(3);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
